// File: rtl/register_file_mp_if.sv
// Decode/writeback bus for the multi-port register file: write ports, read ports
// and the bulk-clear handshake, bundled so the core and the file agree on widths.
`timescale 1ns/1ps
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [NUM_WR-1:0]        reg_write;
    logic [NUM_WR*IDX_W-1:0]  write_index;
    logic [NUM_WR*DATA_W-1:0] write_data;
    logic [NUM_RD*IDX_W-1:0]  read_index;
    logic [NUM_RD*DATA_W-1:0] read_data;
    logic                     clear_start;
    logic                     clear_busy;

    modport master (
        output reg_write, write_index, write_data, read_index, clear_start,
        input  read_data, clear_busy
    );

    modport slave (
        input  reg_write, write_index, write_data, read_index, clear_start,
        output read_data, clear_busy
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file: N combinational read ports, 1-2 prioritised
// write ports, optional write-to-read forwarding and a sequential bulk-clear engine.
`timescale 1ns/1ps
module register_file_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              nRst,
    register_file_mp_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_cnt_next;
    logic              w_busy;

    logic [NUM_WR-1:0] w_we;
    logic [IDX_W-1:0]  w_widx  [NUM_WR];
    logic [DATA_W-1:0] w_wdata [NUM_WR];
    logic [DATA_W-1:0] w_rf    [DEPTH];

    assign w_busy         = (r_state == S_CLEAR);
    assign bus.clear_busy = w_busy;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Register 0 is never stored, so the sweep starts at 1 and stops at DEPTH-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.clear_start) begin
                    w_state_next = S_CLEAR;
                    w_cnt_next   = IDX_W'(1);
                end
            end
            S_CLEAR: begin
                if (r_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign w_widx[gi]  = bus.write_index[gi*IDX_W +: IDX_W];
            assign w_wdata[gi] = bus.write_data[gi*DATA_W +: DATA_W];
            assign w_we[gi]    = bus.reg_write[gi] && (w_widx[gi] != '0) && !w_busy;
        end

        assign w_rf[0] = '0;

        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
            logic              w_hit;
            logic [DATA_W-1:0] w_din;
            logic [DATA_W-1:0] r_q;

            // Ascending scan lets the higher-numbered port override on a collision.
            always_comb begin
                w_hit = 1'b0;
                w_din = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (w_we[p] && (w_widx[p] == IDX_W'(gi))) begin
                        w_hit = 1'b1;
                        w_din = w_wdata[p];
                    end
                end
            end

            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    r_q <= '0;
                end else if (w_busy && (r_cnt == IDX_W'(gi))) begin
                    r_q <= '0;
                end else if (w_hit) begin
                    r_q <= w_din;
                end
            end

            assign w_rf[gi] = r_q;
        end

        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [IDX_W-1:0]  w_ridx;
            logic [DATA_W-1:0] w_rdata;

            assign w_ridx = bus.read_index[gi*IDX_W +: IDX_W];

            always_comb begin
                w_rdata = w_rf[w_ridx];
                if (BYPASS) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (w_we[p] && (w_widx[p] == w_ridx)) begin
                            w_rdata = w_wdata[p];
                        end
                    end
                end
                if (w_busy || (w_ridx == '0)) begin
                    w_rdata = '0;
                end
            end

            assign bus.read_data[gi*DATA_W +: DATA_W] = w_rdata;
        end
    endgenerate
endmodule
